// File: rtl/shift_pkg.sv
// shift_pkg: shared op encodings, FSM states and widths for shift_arbiter
package shift_pkg;
    localparam int SHIFT_W = 32;
    localparam int SHAMT_W = 5;
    localparam logic [1:0] SHIFT_OP_SRL = 2'b00;
    localparam logic [1:0] SHIFT_OP_SLL = 2'b01;
    localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
    localparam logic [1:0] SHIFT_OP_RSV = 2'b11;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;
endpackage

// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: two requester ports plus response port of shift_arbiter
interface shift_arbiter_if;
    import shift_pkg::*;
    logic               req0_valid;
    logic               req0_ready;
    logic [SHIFT_W-1:0] req0_data;
    logic [SHAMT_W-1:0] req0_shamt;
    logic [1:0]         req0_op;
    logic               req1_valid;
    logic               req1_ready;
    logic [SHIFT_W-1:0] req1_data;
    logic [SHAMT_W-1:0] req1_shamt;
    logic [1:0]         req1_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [SHIFT_W-1:0] rsp_data;
    logic               rsp_id;
    logic               rsp_err;
    modport master (
        output req0_valid, req0_data, req0_shamt, req0_op,
        output req1_valid, req1_data, req1_shamt, req1_op, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_op,
        input  req1_valid, req1_data, req1_shamt, req1_op, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/shift_core.sv
// shift_core: combinational SRL/SLL/(SRA with SHIFT_ARBITER_SRA_EN) shifter; reserved ops pass through with err
module shift_core
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [SHIFT_W-1:0] result,
    output logic               err
);
`ifdef SHIFT_ARBITER_SRA_EN
    logic [SHIFT_W-1:0] sra;
    assign sra    = $signed(data) >>> shamt;
    assign result = op == SHIFT_OP_SRL ? data >> shamt :
                    op == SHIFT_OP_SLL ? data << shamt :
                    op == SHIFT_OP_SRA ? sra : data;
    assign err    = op == SHIFT_OP_RSV;
`else
    assign result = op == SHIFT_OP_SRL ? data >> shamt :
                    op == SHIFT_OP_SLL ? data << shamt : data;
    assign err    = op == SHIFT_OP_RSV || op == SHIFT_OP_SRA;
`endif
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of shift_core between two requesters with a registered response (SRA via SHIFT_ARBITER_SRA_EN)
module shift_arbiter
    import shift_pkg::*;
(
    input logic            clk,
    input logic            rst,
    shift_arbiter_if.slave bus
);
    logic [0:0]         state;
    logic               last_grant;
    logic               free;
    logic               grant;
    logic               accept;
    logic [SHIFT_W-1:0] sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    logic [1:0]         sel_op;
    logic [SHIFT_W-1:0] result;
    logic               err;

    assign bus.rsp_valid  = state == ST_RESP;
    assign free           = !rst && (state == ST_IDLE || bus.rsp_ready);
    assign grant          = (bus.req0_valid && bus.req1_valid) ? !last_grant : bus.req1_valid;
    assign accept         = free && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;
    assign sel_data       = grant ? bus.req1_data  : bus.req0_data;
    assign sel_shamt      = grant ? bus.req1_shamt : bus.req0_shamt;
    assign sel_op         = grant ? bus.req1_op    : bus.req0_op;

    shift_core u_core (
        .data   (sel_data),
        .shamt  (sel_shamt),
        .op     (sel_op),
        .result (result),
        .err    (err)
    );

    // FSM, round-robin pointer and response registers; a drained response with no new accept returns to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            bus.rsp_data <= '0;
            bus.rsp_id   <= 1'b0;
            bus.rsp_err  <= 1'b0;
        end else if (accept) begin
            state        <= ST_RESP;
            last_grant   <= grant;
            bus.rsp_data <= result;
            bus.rsp_id   <= grant;
            bus.rsp_err  <= err;
        end else if (free) begin
            state        <= ST_IDLE;
        end
    end
endmodule
